// File: rtl/alu_exec_pkg.sv
// Shared ALUOp encodings for the RV32I execute unit, plus a shift-op helper.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_PASS = 4'd10,
    OP_NOP  = 4'd15
  } alu_op_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_serial_shifter.sv
// Iterative one-bit-per-cycle shifter: load value and amount, then shift until
// the counter drains. `done` flags the cycle whose edge applies the final shift.
module serial_shifter #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [SHW-1:0]  amt,
  input  logic [XLEN-1:0] din,
  input  logic            left,
  input  logic            arith,
  output logic [XLEN-1:0] shifted,
  output logic            done
);

  logic [XLEN-1:0] sreg;
  logic [SHW-1:0]  cnt;
  logic            left_q, arith_q;

  // Value the register takes at the next edge while counting.
  assign shifted = left_q ? {sreg[XLEN-2:0], 1'b0}
                          : {arith_q & sreg[XLEN-1], sreg[XLEN-1:1]};
  assign done    = (cnt == SHW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      sreg    <= din;
      cnt     <= amt;
      left_q  <= left;
      arith_q <= arith;
    end else if (cnt != '0) begin
      sreg <= shifted;
      cnt  <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle integer execute unit: single-cycle logic/arith ops, iterative
// shifts, registered result and compare flags behind a valid/ready handshake.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            accept, start_shift, lt_c, ltu_c, sh_done;
  logic [XLEN-1:0] op_res, sh_next;

  assign in_ready    = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign out_valid   = (state_q == S_DONE);
  assign accept      = in_valid && in_ready;
  assign start_shift = is_shift(alu_op) && (src_b[SHW-1:0] != '0);
  assign lt_c        = $signed(src_a) < $signed(src_b);
  assign ltu_c       = src_a < src_b;

  // Shifts reaching this mux have k=0, so they pass src_a unchanged.
  always_comb begin
    op_res = '0;
    case (alu_op)
      OP_ADD:                 op_res = src_a + src_b;
      OP_SUB:                 op_res = src_a - src_b;
      OP_SLL, OP_SRL, OP_SRA: op_res = src_a;
      OP_SLT:                 op_res = XLEN'(lt_c);
      OP_SLTU:                op_res = XLEN'(ltu_c);
      OP_XOR:                 op_res = src_a ^ src_b;
      OP_OR:                  op_res = src_a | src_b;
      OP_AND:                 op_res = src_a & src_b;
      OP_PASS:                op_res = src_b;
      default:                op_res = '0;
    endcase
  end

  serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && start_shift),
    .amt     (src_b[SHW-1:0]),
    .din     (src_a),
    .left    (alu_op == OP_SLL),
    .arith   (alu_op == OP_SRA),
    .shifted (sh_next),
    .done    (sh_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = start_shift ? S_SHIFT : S_DONE;
      S_SHIFT: if (sh_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = accept ? (start_shift ? S_SHIFT : S_DONE) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      result  <= '0;
      zero    <= 1'b0;
      lt      <= 1'b0;
      ltu     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lt  <= lt_c;
        ltu <= ltu_c;
        if (!start_shift) begin
          result <= op_res;
          zero   <= (op_res == '0);
        end
      end else if (state_q == S_SHIFT && sh_done) begin
        result <= sh_next;
        zero   <= (sh_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: table of single-cycle ops run back-to-back,
// plus hand sequences for reset, shift latency, backpressure and mid-shift reset.
module tb_alu_exec;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                         XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9,
                         PASS = 4'd10, NOP = 4'd15;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] src_a = '0, src_b = '0, result;
  logic        zero, lt, ltu;

  int checks = 0, errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z, l, lu;
  } vec_t;

  vec_t vecs[14];

  alu_exec #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .lt(lt), .ltu(ltu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
  endtask

  // Accept one shift, then count edges until out_valid; in_ready must stay low meanwhile.
  task automatic run_shift(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n = 0;
    logic rdy_seen = 1'b0;
    drive(op, a, b);
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      n++;
    end
    chk({name, "_latency"}, n, lat);
    chk({name, "_result"}, result, exp);
    chk({name, "_busy_ready"}, {31'd0, rdy_seen}, 32'd0);
    step();
    chk({name, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{OR,   32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{AND,  32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{PASS, 32'h00000000, 32'h12345000, 32'h12345000, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{4'd12,32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{NOP,  32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{AND,  32'h00000005, 32'h0000000A, 32'h00000000, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{SLL,  32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{SRA,  32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b0};

    // Reset held with a request pending: nothing may be latched.
    drive(ADD, 32'd1, 32'd1);
    repeat (3) step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, zero, lt, ltu}, 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_idle_valid", {31'd0, out_valid}, 32'd0);

    // Table: back-to-back, one result per edge with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_flags", i), {29'd0, zero, lt, ltu},
          {29'd0, vecs[i].z, vecs[i].l, vecs[i].lu});
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("table_drain", {31'd0, out_valid}, 32'd0);

    // Iterative shifts: latency equals the shift amount.
    run_shift("sra4", SRA, 32'h80000000, 32'd4, 32'hF8000000, 4);
    run_shift("srl3", SRL, 32'h80000000, 32'd3, 32'h10000000, 3);
    run_shift("sll31", SLL, 32'h00000001, 32'd31, 32'h80000000, 31);
    run_shift("sll1_hi", SLL, 32'hC0000001, 32'hFFFFFFE1, 32'h80000002, 1);

    // Backpressure: result held, no accept while stalled, then handoff.
    out_ready = 1'b0;
    drive(SLT, 32'hFFFFFFFF, 32'h00000001);
    step();
    drive(ADD, 32'h00000010, 32'h00000020);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_result", c), result, 32'd1);
      chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_handoff_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_after_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_after_result", result, 32'd1);

    // Reset in the middle of a long shift, then recover.
    drive(SRL, 32'hFFFFFFFF, 32'd20);
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("mid_shift_busy", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    drive(ADD, 32'd2, 32'd3);
    step();
    in_valid = 1'b0;
    chk("recover_valid", {31'd0, out_valid}, 32'd1);
    chk("recover_result", result, 32'd5);
    repeat (25) step();
    chk("recover_no_stale", result, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
